// File: rtl/if_id_buffer.sv
// if_id_buffer: elastic IF/ID instruction FIFO with a NOP bubble on empty.
// Optional same-cycle bypass when IF_ID_BYPASS_EN is defined.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  input  logic [31:0]              IN_PC,
  input  logic [31:0]              IN_INSTR,
  output logic                     IN_READY,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [31:0]              OUT_PC,
  output logic [31:0]              OUT_INSTR,
  output logic [24:0]              OUT_IMM_FIELD,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_last_pc;

  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_byp_take;
  logic w_push;
  logic w_wr;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

`ifdef IF_ID_BYPASS_EN
  assign w_byp = IN_VALID & w_empty & ~FLUSH;
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_take = w_byp & OUT_READY;
  assign w_push     = IN_VALID & ~w_full & ~FLUSH;
  assign w_wr       = w_push & ~w_byp_take;
  assign w_pop      = ~w_empty & OUT_READY & ~FLUSH;

  assign IN_READY  = ~w_full;
  assign OUT_VALID = ~w_empty | w_byp;
  assign COUNT     = r_count;

  // Head selection: storage, bypassed fetch word, or bubble.
  always_comb begin
    OUT_PC    = r_last_pc;
    OUT_INSTR = NOP_INSN;
    if (!w_empty) begin
      OUT_PC    = r_pc_mem[r_rd_ptr];
      OUT_INSTR = r_ins_mem[r_rd_ptr];
    end else if (w_byp) begin
      OUT_PC    = IN_PC;
      OUT_INSTR = IN_INSTR;
    end
  end

  assign OUT_IMM_FIELD = OUT_INSTR[31:7];

  // Entry storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_pc_mem[r_wr_ptr]  <= IN_PC;
      r_ins_mem[r_wr_ptr] <= IN_INSTR;
    end
  end

  // Pointers, occupancy and last-consumed PC.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
    end else if (FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_last_pc <= r_pc_mem[r_rd_ptr];
      end else if (w_byp_take) begin
        r_last_pc <= IN_PC;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: vector table, corner sequences and randomized
// traffic against a queue-based model of the IF/ID buffer.
module tb_if_id_buffer;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_PC = '0;
  logic [31:0] IN_INSTR = '0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_INSTR;
  logic [24:0] OUT_IMM_FIELD;
  logic [1:0]  COUNT;

  int errors = 0;
  int checks = 0;

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_PC(IN_PC), .IN_INSTR(IN_INSTR),
    .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_PC(OUT_PC), .OUT_INSTR(OUT_INSTR),
    .OUT_IMM_FIELD(OUT_IMM_FIELD), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {pc[15:0], 16'h5A13} ^ 32'h8000_0000;
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    int          ecnt;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic fl,
                              input logic ordy, input logic ev,
                              input logic [31:0] epc,
                              input logic [31:0] eins,
                              input int ecnt, input logic erdy);
    vec_t t;
    t.v = v; t.pc = pc; t.ins = ins; t.fl = fl; t.ordy = ordy;
    t.ev = ev; t.epc = epc; t.eins = eins; t.ecnt = ecnt; t.erdy = erdy;
    tbl.push_back(t);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last_pc = '0;

  task automatic model_check(input string tag);
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    ev   = (q.size() > 0) || (BYP && IN_VALID && !FLUSH);
    epc  = last_pc;
    eins = NOP;
    if (q.size() > 0) begin
      epc  = q[0].pc;
      eins = q[0].ins;
    end else if (ev) begin
      epc  = IN_PC;
      eins = IN_INSTR;
    end
    chk({tag, " valid"}, 32'(OUT_VALID), 32'(ev));
    chk({tag, " pc"}, OUT_PC, epc);
    chk({tag, " instr"}, OUT_INSTR, eins);
    chk({tag, " imm"}, 32'(OUT_IMM_FIELD), 32'(eins[31:7]));
    chk({tag, " count"}, 32'(COUNT), q.size());
    chk({tag, " in_ready"}, 32'(IN_READY), 32'(q.size() < DEPTH));
  endtask

  task automatic model_step();
    bit in_rdy;
    ent_t e;
    if (FLUSH) begin
      q.delete();
      return;
    end
    in_rdy = (q.size() < DEPTH);
    if (q.size() == 0 && BYP && IN_VALID) begin
      if (OUT_READY) last_pc = IN_PC;
      else begin
        e.pc = IN_PC; e.ins = IN_INSTR;
        q.push_back(e);
      end
      return;
    end
    if (q.size() > 0 && OUT_READY) begin
      last_pc = q[0].pc;
      void'(q.pop_front());
    end
    if (IN_VALID && in_rdy) begin
      e.pc = IN_PC; e.ins = IN_INSTR;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl,
                       input logic ordy);
    @(negedge CLK);
    IN_VALID = v; IN_PC = pc; IN_INSTR = ins;
    FLUSH = fl; OUT_READY = ordy;
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset valid", 32'(OUT_VALID), 32'd0);
    chk("reset instr", OUT_INSTR, NOP);
    chk("reset pc", OUT_PC, 32'd0);
    chk("reset count", 32'(COUNT), 32'd0);
    chk("reset in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;

`ifndef IF_ID_BYPASS_EN
    add(1, 32'h000, mk(32'h000), 0, 1, 0, 32'h000, NOP, 0, 1);
    add(1, 32'h004, mk(32'h004), 0, 1, 1, 32'h000, mk(32'h000), 1, 1);
    add(1, 32'h008, mk(32'h008), 0, 1, 1, 32'h004, mk(32'h004), 1, 1);
    add(0, 32'h000, 32'h0,       0, 1, 1, 32'h008, mk(32'h008), 1, 1);
    add(0, 32'h000, 32'h0,       0, 1, 0, 32'h008, NOP, 0, 1);
    add(1, 32'h100, mk(32'h100), 0, 0, 0, 32'h008, NOP, 0, 1);
    add(1, 32'h104, mk(32'h104), 0, 0, 1, 32'h100, mk(32'h100), 1, 1);
    add(1, 32'h108, mk(32'h108), 0, 0, 1, 32'h100, mk(32'h100), 2, 0);
    add(1, 32'h108, mk(32'h108), 0, 1, 1, 32'h100, mk(32'h100), 2, 0);
    add(1, 32'h108, mk(32'h108), 0, 1, 1, 32'h104, mk(32'h104), 1, 1);
    add(0, 32'h000, 32'h0,       0, 1, 1, 32'h108, mk(32'h108), 1, 1);
    add(0, 32'h000, 32'h0,       0, 0, 0, 32'h108, NOP, 0, 1);
    add(1, 32'h1F8, mk(32'h1F8), 0, 0, 0, 32'h108, NOP, 0, 1);
    add(1, 32'h1FC, mk(32'h1FC), 0, 0, 1, 32'h1F8, mk(32'h1F8), 1, 1);
    add(1, 32'h200, mk(32'h200), 1, 1, 1, 32'h1F8, mk(32'h1F8), 2, 0);
    add(0, 32'h000, 32'h0,       0, 1, 0, 32'h108, NOP, 0, 1);
    add(0, 32'h000, 32'h0,       0, 1, 0, 32'h108, NOP, 0, 1);
    add(1, 32'h300, 32'hFE00_0EE3, 0, 0, 0, 32'h108, NOP, 0, 1);
    add(0, 32'h000, 32'h0,       0, 1, 1, 32'h300, 32'hFE00_0EE3, 1, 1);
    add(0, 32'h000, 32'h0,       0, 0, 0, 32'h300, NOP, 0, 1);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("vec%0d valid", i), 32'(OUT_VALID), 32'(tbl[i].ev));
      chk($sformatf("vec%0d pc", i), OUT_PC, tbl[i].epc);
      chk($sformatf("vec%0d instr", i), OUT_INSTR, tbl[i].eins);
      chk($sformatf("vec%0d count", i), 32'(COUNT), tbl[i].ecnt);
      chk($sformatf("vec%0d in_ready", i), 32'(IN_READY),
          32'(tbl[i].erdy));
    end
    chk("imm field", 32'(OUT_IMM_FIELD), 32'd0);
    drive(1, 32'h400, 32'hFE00_0EE3, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    chk("imm FE000EE3", 32'(OUT_IMM_FIELD), 32'h1FC001D);
    drive(0, 32'h0, 32'h0, 1, 0);
`else
    drive(1, 32'h40, mk(32'h40), 0, 1);
    chk("bypass valid", 32'(OUT_VALID), 32'd1);
    chk("bypass pc", OUT_PC, 32'h40);
    chk("bypass instr", OUT_INSTR, mk(32'h40));
    drive(0, 32'h0, 32'h0, 0, 0);
    chk("bypass count", 32'(COUNT), 32'd0);
    chk("bypass after valid", 32'(OUT_VALID), 32'd0);
    chk("bypass last pc", OUT_PC, 32'h40);
    drive(0, 32'h0, 32'h0, 1, 0);
`endif

    drive(1, 32'h500, mk(32'h500), 0, 0);
    drive(1, 32'h504, mk(32'h504), 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    chk("pre-reset count", 32'(COUNT), 32'd2);
    RESET = 1'b0;
    #1;
    chk("async reset count", 32'(COUNT), 32'd0);
    chk("async reset valid", 32'(OUT_VALID), 32'd0);
    chk("async reset instr", OUT_INSTR, NOP);
    chk("async reset pc", OUT_PC, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    q.delete();
    last_pc = '0;

    for (int c = 0; c < 600; c++) begin
      logic        v;
      logic [31:0] pc;
      logic        fl;
      logic        ordy;
      v    = ($urandom_range(0, 3) != 0);
      pc   = {$urandom_range(0, 16'hFFFF), 2'b00};
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(v, pc, $urandom, fl, ordy);
      model_check($sformatf("rnd%0d", c));
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
